adder_result_sink: RTL and testbench

- Downstream stage of the 4-stage pipelined 8-bit adder.
- The adder has no valid signal and cannot stall. This block tracks an issue token through a LAT-cycle delay line and captures each {cout,sum} result when its token emerges.
- Captured results are buffered in a DEPTH-entry FIFO and presented on a valid/ready output interface.
- It also generates issue_ok, a credit signal the upstream issuer obeys so that the FIFO never overflows.

---
 rtl/adder_sink_pkg.sv | 11 +
 rtl/adder_sink_fifo.sv | 63 ++++++
 rtl/adder_result_sink.sv | 109 ++++++++++
 tb/tb_adder_result_sink.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_sink_pkg.sv
// rtl/adder_sink_pkg.sv - shared result type and default sizing for the adder result sink
package adder_sink_pkg;

  localparam int RES_W     = 9;
  localparam int DEF_LAT   = 5;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_ACC_W = 16;

  typedef logic [RES_W-1:0] result_t;

endpackage

// File: rtl/adder_sink_fifo.sv
// rtl/adder_sink_fifo.sv - synchronous result FIFO with occupancy count and registered storage
module adder_sink_fifo
  import adder_sink_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  result_t wdata,
  output logic    full,
  output logic    empty,
  output logic [AW:0] level,
  output result_t head
);

  result_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

  // A push into a full FIFO is only legal when the head leaves in the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head reads as zero while empty so the output never shows stale storage.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adder_result_sink.sv
// rtl/adder_result_sink.sv - captures pipelined adder results via a token delay line into a credited FIFO
// Optional accumulator of popped results: ADDER_SINK_ACCUM_EN
module adder_result_sink
  import adder_sink_pkg::*;
#(
  parameter int LAT   = DEF_LAT,
  parameter int DEPTH = DEF_DEPTH,
`ifdef ADDER_SINK_ACCUM_EN
  parameter int ACC_W = DEF_ACC_W,
`endif
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             cout,
  input  logic [7:0]       sum,
  output logic             issue_ok,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_data,
  output logic [LW-1:0]    level,
  output logic             overflow
`ifdef ADDER_SINK_ACCUM_EN
  ,
  input  logic             acc_clear,
  output logic [ACC_W-1:0] acc_value
`endif
);

  localparam int IW = $clog2(LAT + 1);

  logic [LAT-1:0] tokens;
  logic [IW-1:0]  inflight;
  logic           cap;
  logic           pop;
  logic           push;
  logic           full;
  logic           empty;
  result_t        head;

  assign cap = tokens[LAT-1];

  // Each token marks the edge at which its result is stable on {cout,sum}.
  always_ff @(posedge clk) begin
    if (rst) begin
      tokens <= '0;
    end else begin
      tokens[0] <= issue_valid;
      for (int i = 1; i < LAT; i++) begin
        tokens[i] <= tokens[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({issue_valid, cap})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Credit uses registered state only; a pop this cycle frees space next cycle.
  assign issue_ok = (int'(level) + int'(inflight)) < DEPTH;

  assign pop  = out_valid & out_ready;
  assign push = cap & (~full | pop);

  adder_sink_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({cout, sum}),
    .full  (full),
    .empty (empty),
    .level (level),
    .head  (head)
  );

  assign out_valid = ~empty;
  assign out_data  = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (cap & full & ~pop) begin
      overflow <= 1'b1;
    end
  end

`ifdef ADDER_SINK_ACCUM_EN
  always_ff @(posedge clk) begin
    if (rst || acc_clear) begin
      acc_value <= '0;
    end else if (pop) begin
      acc_value <= acc_value + ACC_W'(out_data);
    end
  end
`endif

endmodule

// File: tb/tb_adder_result_sink.sv
// tb/tb_adder_result_sink.sv - directed self-checking bench for adder_result_sink with a delay-line adder model
module tb_adder_result_sink;

  localparam int LAT = 5;

  logic       clk;
  logic       rst;
  logic       issue_valid;
  logic       cout;
  logic [7:0] sum;
  logic       issue_ok;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_data;
  logic [2:0] level;
  logic       overflow;
`ifdef ADDER_SINK_ACCUM_EN
  logic        acc_clear;
  logic [15:0] acc_value;
`endif

  logic [7:0] ina;
  logic [7:0] inb;
  logic       cin;
  logic [8:0] pipe [LAT];

  int checks = 0;
  int errors = 0;
  int accepted;

  logic [7:0] bp_a [4];
  logic [7:0] bp_b [4];
  logic       bp_c [4];
  logic [8:0] bp_r [4];

  adder_result_sink dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .cout        (cout),
    .sum         (sum),
    .issue_ok    (issue_ok),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .overflow    (overflow)
`ifdef ADDER_SINK_ACCUM_EN
    ,
    .acc_clear   (acc_clear),
    .acc_value   (acc_value)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder model: result sampled at posedge k is stable on {cout,sum} for capture at k+LAT.
  always @(posedge clk) begin
    pipe[0] <= {1'b0, ina} + {1'b0, inb} + {8'd0, cin};
    for (int i = 1; i < LAT; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end
  assign {cout, sum} = pipe[LAT-1];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c);
    ina = a;
    inb = b;
    cin = c;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0;
    out_ready = 1'b0;
    ina = 8'h00;
    inb = 8'h00;
    cin = 1'b0;
`ifdef ADDER_SINK_ACCUM_EN
    acc_clear = 1'b0;
`endif
    bp_a[0] = 8'h12; bp_b[0] = 8'h34; bp_c[0] = 1'b0; bp_r[0] = 9'h046;
    bp_a[1] = 8'h80; bp_b[1] = 8'h80; bp_c[1] = 1'b0; bp_r[1] = 9'h100;
    bp_a[2] = 8'hAA; bp_b[2] = 8'h55; bp_c[2] = 1'b0; bp_r[2] = 9'h0FF;
    bp_a[3] = 8'hF0; bp_b[3] = 8'h0F; bp_c[3] = 1'b1; bp_r[3] = 9'h100;

    tick();
    do_reset();
    tick();
    check("reset_level", 32'(level), 0);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_issue_ok", 32'(issue_ok), 1);
    check("reset_overflow", 32'(overflow), 0);
    check("reset_out_data", 32'(out_data), 0);

    // Single result latency: capture at k+LAT, visible the cycle after.
    out_ready = 1'b1;
    issue(8'h7F, 8'h01, 1'b0);
    repeat (LAT - 1) tick();
    check("latency_not_early", 32'(out_valid), 0);
    tick();
    check("latency_valid", 32'(out_valid), 1);
    check("latency_data", 32'(out_data), 32'h080);
    tick();
    check("latency_popped", 32'(out_valid), 0);

    // Two back-to-back results held with backpressure.
    out_ready = 1'b0;
    issue(8'hFF, 8'hFF, 1'b1);
    issue(8'h00, 8'h00, 1'b0);
    repeat (LAT) tick();
    check("b2b_level", 32'(level), 2);
    check("b2b_first", 32'(out_data), 32'h1FF);
    out_ready = 1'b1;
    tick();
    check("b2b_second", 32'(out_data), 32'h000);
    check("b2b_level_after_pop", 32'(level), 1);
    tick();
    check("b2b_empty", 32'(out_valid), 0);

    // Credit-limited issue under full backpressure.
    out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      if (issue_ok && accepted < 4) begin
        ina = bp_a[accepted];
        inb = bp_b[accepted];
        cin = bp_c[accepted];
        issue_valid = 1'b1;
        accepted++;
      end else begin
        issue_valid = issue_ok;
      end
      tick();
    end
    issue_valid = 1'b0;
    tick();
    check("credit_accepted", 32'(accepted), 4);
    check("credit_issue_ok", 32'(issue_ok), 0);
    check("credit_level", 32'(level), 4);
    check("credit_overflow", 32'(overflow), 0);
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("credit_drain_valid", 32'(out_valid), 1);
      check("credit_drain_data", 32'(out_data), 32'(bp_r[j]));
      tick();
    end
    check("credit_drained_level", 32'(level), 0);
    check("credit_restored", 32'(issue_ok), 1);

    // Forced overflow: issue 6 ignoring credit.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      issue(8'(i + 1), 8'h00, 1'b0);
    end
    repeat (LAT + 1) tick();
    check("ovf_level", 32'(level), 4);
    check("ovf_flag", 32'(overflow), 1);
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("ovf_drain_data", 32'(out_data), 32'(j + 1));
      tick();
    end
    check("ovf_drained_valid", 32'(out_valid), 0);
    check("ovf_sticky", 32'(overflow), 1);

    // Reset while results are in flight; a token during reset is ignored.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(8'h20, 8'(i), 1'b0);
    end
    tick();
    tick();
    rst = 1'b1;
    issue_valid = 1'b1;
    tick();
    rst = 1'b0;
    issue_valid = 1'b0;
    check("midrst_overflow", 32'(overflow), 0);
    check("midrst_issue_ok", 32'(issue_ok), 1);
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      check("midrst_no_capture", 32'(out_valid), 0);
    end
    check("midrst_level", 32'(level), 0);
    for (int i = 0; i < 3; i++) begin
      issue(8'h01, 8'h01, 1'b0);
    end
    check("midrst_credit_3", 32'(issue_ok), 1);
    issue(8'h01, 8'h01, 1'b0);
    check("midrst_credit_4", 32'(issue_ok), 0);
    repeat (LAT) tick();
    check("midrst_refill_level", 32'(level), 4);
    out_ready = 1'b1;
    repeat (5) tick();
    check("midrst_refill_drained", 32'(level), 0);

`ifdef ADDER_SINK_ACCUM_EN
    do_reset();
    check("acc_reset", 32'(acc_value), 0);
    out_ready = 1'b0;
    issue(8'h7F, 8'h01, 1'b0);
    issue(8'hFF, 8'hFF, 1'b1);
    issue(8'h01, 8'h00, 1'b0);
    repeat (LAT + 1) tick();
    check("acc_level", 32'(level), 3);
    out_ready = 1'b1;
    repeat (3) tick();
    check("acc_sum", 32'(acc_value), 32'h0280);
    check("acc_drained", 32'(level), 0);
    out_ready = 1'b0;
    issue(8'h05, 8'h00, 1'b0);
    repeat (LAT + 1) tick();
    check("acc_clear_level_before", 32'(level), 1);
    acc_clear = 1'b1;
    out_ready = 1'b1;
    tick();
    acc_clear = 1'b0;
    out_ready = 1'b0;
    check("acc_clear_wins", 32'(acc_value), 0);
    check("acc_clear_popped", 32'(level), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
